// File: rtl/hack_exec_stage.sv
// ============================================================================
// Module      : hack_exec_stage
// Description : Multi-cycle Hack CPU execute stage driving an external ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hack_exec_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic [15:0] inM,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_ctrl,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM,
  output logic [14:0] pc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] a_q, d_q, ir_q, res_q;
  logic        res_zr_q, res_ng_q;
  logic [14:0] pc_q;
  logic [15:0] alu_x_q, alu_y_q;
  logic [5:0]  alu_ctrl_q;
  logic        transfer;
  logic        jump_taken;

  assign transfer   = instr_valid & instr_ready;
  assign jump_taken = (ir_q[2] & res_ng_q) | (ir_q[1] & res_zr_q) |
                      (ir_q[0] & ~res_zr_q & ~res_ng_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (transfer && instr[15]) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == S_IDLE);
    writeM      = (state_q == S_WB) & ir_q[3];
  end

  // Write-back uses the pre-update A for both the M address and the jump target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= 16'd0;
      d_q        <= 16'd0;
      ir_q       <= 16'd0;
      res_q      <= 16'd0;
      res_zr_q   <= 1'b0;
      res_ng_q   <= 1'b0;
      pc_q       <= 15'd0;
      alu_x_q    <= 16'd0;
      alu_y_q    <= 16'd0;
      alu_ctrl_q <= 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (transfer) begin
            if (!instr[15]) begin
              a_q  <= instr;
              pc_q <= pc_q + 15'd1;
            end else begin
              ir_q       <= instr;
              alu_x_q    <= d_q;
              alu_y_q    <= instr[12] ? inM : a_q;
              alu_ctrl_q <= instr[11:6];
            end
          end
        end
        S_EXEC: begin
          res_q    <= alu_out;
          res_zr_q <= alu_zr;
          res_ng_q <= alu_ng;
        end
        S_WB: begin
          if (ir_q[5]) a_q <= res_q;
          if (ir_q[4]) d_q <= res_q;
          pc_q <= jump_taken ? a_q[14:0] : pc_q + 15'd1;
        end
        default: ;
      endcase
    end
  end

  assign alu_x    = alu_x_q;
  assign alu_y    = alu_y_q;
  assign alu_ctrl = alu_ctrl_q;
  assign outM     = res_q;
  assign addressM = a_q[14:0];
  assign pc       = pc_q;

endmodule

`default_nettype wire
